// File: rtl/line_data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
//   Shared types and constants for the line-granular backing store
//   (line_data_memory).
//   - state_t       : controller state (IDLE / BUSY / RESP)
//   - DEFAULT_*     : default geometry and access latency
//   - offset_width  : number of byte-offset address bits inside one line
// -----------------------------------------------------------------------------
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_BLOCK_SIZE = 16;
    localparam int DEFAULT_MEM_BYTES  = 16384;
    localparam int DEFAULT_DELAY      = 50;

    // Byte-offset bits inside one line; BLOCK_SIZE is a power of two.
    function automatic int offset_width(input int block_size);
        return $clog2(block_size);
    endfunction

endpackage

// File: rtl/line_data_memory_if.sv
// -----------------------------------------------------------------------------
// line_data_memory_if
//   Request/response bus between the data cache (master) and the backing store
//   (slave).
//
//   Handshake: a request is transferred on a rising edge where is_input_valid
//   and mem_ready are both 1 and exactly one of mem_read/mem_write is 1. The
//   master holds addr/op/din stable until it sees mem_ready; the slave ignores
//   everything while mem_ready is 0. Read data comes back as a one-cycle
//   is_output_valid pulse with dout; there is no back-pressure on responses.
//
//   Signals:
//     is_input_valid, addr[31:0], mem_read, mem_write, din[LINE_W-1:0]  (m->s)
//     is_output_valid, dout[LINE_W-1:0], mem_ready                      (s->m)
// -----------------------------------------------------------------------------
interface line_data_memory_if #(
    parameter int BLOCK_SIZE = data_mem_pkg::DEFAULT_BLOCK_SIZE
);
    localparam int LINE_W = BLOCK_SIZE * 8;

    logic              is_input_valid;
    logic [31:0]       addr;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] din;
    logic              is_output_valid;
    logic [LINE_W-1:0] dout;
    logic              mem_ready;

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  is_output_valid, dout, mem_ready
    );

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output is_output_valid, dout, mem_ready
    );
endinterface

// File: rtl/line_data_memory_delay_counter.sv
// -----------------------------------------------------------------------------
// mem_delay_counter
//   Access-latency down-counter.
//   Ports:
//     clk, reset (sync, active-high) : clock / reset (count -> 0)
//     load, load_value               : load strobe and value (wins over dec)
//     dec                            : decrement by one, saturating at zero
//     count                          : current value
//     is_zero                        : count == 0
// -----------------------------------------------------------------------------
module mem_delay_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             is_zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/line_data_memory.sv
// -----------------------------------------------------------------------------
// line_data_memory
//   Line-granular backing store behind the data cache. Accepts one whole-line
//   read or write at a time, completes it DELAY cycles after acceptance, and
//   returns read data as a one-cycle is_output_valid pulse.
//
//   Ports:
//     clk        : clock
//     reset      : synchronous, active-high; resets control only, never contents
//     bus        : line_data_memory_if.slave (request/response handshake)
//     dbg_state  : current controller state
//   Optional (macro DATA_MEM_STATS_EN):
//     read_count, write_count : completed reads / writes since reset (wrap 2^32)
//
//   Line index = (addr >> log2(BLOCK_SIZE)) mod (MEM_BYTES / BLOCK_SIZE);
//   addresses beyond capacity alias silently.
// -----------------------------------------------------------------------------
module line_data_memory
    import data_mem_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int MEM_BYTES  = DEFAULT_MEM_BYTES,
    parameter int DELAY      = DEFAULT_DELAY
) (
    input  logic                clk,
    input  logic                reset,
    line_data_memory_if.slave   bus,
    output state_t              dbg_state
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [31:0]         read_count,
    output logic [31:0]         write_count
`endif
);

    localparam int LINE_W    = BLOCK_SIZE * 8;
    localparam int OFFSET_W  = offset_width(BLOCK_SIZE);
    localparam int NUM_LINES = MEM_BYTES / BLOCK_SIZE;
    localparam int INDEX_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CNT_W     = $clog2(DELAY + 1);

    // Storage starts zeroed; reset deliberately leaves it untouched.
    logic [LINE_W-1:0] mem [NUM_LINES] = '{default: '0};

    state_t             state;
    state_t             next_state;

    logic [INDEX_W-1:0] idx_q;
    logic               op_write_q;
    logic [LINE_W-1:0]  din_q;

    logic               out_valid_q;
    logic [LINE_W-1:0]  dout_q;

    logic [31:0]        line_num;
    logic [INDEX_W-1:0] req_index;
    logic               req_legal;
    logic               accept;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_value;
    logic               done;
    logic               read_done;
    logic               write_done;

    // Byte-offset bits carry no information for a whole-line access.
    logic               unused_offset_bits;
    assign unused_offset_bits = ^bus.addr[OFFSET_W-1:0];

    assign line_num  = bus.addr >> OFFSET_W;
    assign req_index = INDEX_W'(line_num % 32'(NUM_LINES));
    assign req_legal = bus.is_input_valid && (bus.mem_read ^ bus.mem_write);
    assign accept    = (state == IDLE) && req_legal;

    assign done       = (state == BUSY) && cnt_zero;
    assign read_done  = done && !op_write_q;
    assign write_done = done &&  op_write_q;

    mem_delay_counter #(
        .WIDTH (CNT_W)
    ) u_delay_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (CNT_W'(DELAY - 1)),
        .dec        (state == BUSY),
        .count      (cnt_value),
        .is_zero    (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_legal) next_state = BUSY;
            BUSY:    if (cnt_zero)  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch: din is captured only here, so later changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q      <= req_index;
            op_write_q <= bus.mem_write;
            din_q      <= bus.din;
        end
    end

    // Response path: the pulse is set at completion and cleared in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            out_valid_q <= read_done;
            if (read_done) begin
                dout_q <= mem[idx_q];
            end
        end
    end

    // Array write; an operation aborted by reset never reaches completion.
    always @(posedge clk) begin
        if (!reset && write_done) begin
            mem[idx_q] <= din_q;
        end
    end

`ifdef DATA_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (read_done)  read_count  <= read_count  + 32'd1;
            if (write_done) write_count <= write_count + 32'd1;
        end
    end
`endif

    assign bus.mem_ready       = (state == IDLE) && !reset;
    assign bus.is_output_valid = out_valid_q;
    assign bus.dout            = dout_q;
    assign dbg_state           = state;

endmodule
